// File: rtl/ldtu_rx_word_aligner.sv
// LiTE-DTU receive lane word aligner.
// Searches the 64-bit window {data_in, prev_word} for the DTU synch word,
// locks once the match has repeated at one offset, then delivers aligned
// words and watches synch words for loss of lock.
module ldtu_rx_word_aligner #(
    parameter int Nbits_32    = 32,
    parameter int LockCount   = 4,
    parameter int UnlockCount = 3
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic [Nbits_32-1:0] data_in,
    input  logic                data_valid,
    input  logic                synch_mode,
    input  logic [Nbits_32-1:0] synch_pattern,
    input  logic                realign,
    output logic [Nbits_32-1:0] data_out,
    output logic                data_out_valid,
    output logic                locked,
    output logic [1:0]          align_state,
    output logic [4:0]          bit_offset,
    output logic [7:0]          lock_loss_cnt
);

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        CONFIRM = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_CNT   = 4'(LockCount);
    localparam logic [3:0] UNLOCK_CNT = 4'(UnlockCount);

    state_t              state_q, state_d;
    logic [4:0]          bit_offset_q, bit_offset_d;
    logic [Nbits_32-1:0] prev_word_q, prev_word_d;
    logic                prev_valid_q, prev_valid_d;
    logic [3:0]          match_cnt_q, match_cnt_d;
    logic [3:0]          miss_cnt_q, miss_cnt_d;
    logic [Nbits_32-1:0] data_out_q, data_out_d;
    logic                data_out_valid_q, data_out_valid_d;
    logic [7:0]          lock_loss_cnt_q, lock_loss_cnt_d;

    logic [2*Nbits_32-1:0] concat;
    logic [Nbits_32-1:0]   window;
    logic                  match;

    // Select the candidate word at the current offset and compare to synch.
    always_comb begin
        concat = {data_in, prev_word_q};
        window = concat[bit_offset_q +: Nbits_32];
        match  = (window == synch_pattern);
    end

    // Next-state logic: realign overrides everything, otherwise advance only on valid words.
    always_comb begin
        state_d          = state_q;
        bit_offset_d     = bit_offset_q;
        prev_word_d      = prev_word_q;
        prev_valid_d     = prev_valid_q;
        match_cnt_d      = match_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        lock_loss_cnt_d  = lock_loss_cnt_q;

        if (realign) begin
            // The word arriving with realign is dropped; the search restarts from offset 0.
            state_d      = HUNT;
            bit_offset_d = 5'd0;
            prev_valid_d = 1'b0;
            match_cnt_d  = 4'd0;
            miss_cnt_d   = 4'd0;
        end else if (data_valid) begin
            prev_word_d  = data_in;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                unique case (state_q)
                    HUNT: begin
                        if (match) begin
                            match_cnt_d = 4'd1;
                            if (LOCK_CNT == 4'd1) begin
                                state_d    = LOCKED;
                                miss_cnt_d = 4'd0;
                            end else begin
                                state_d = CONFIRM;
                            end
                        end else begin
                            bit_offset_d = bit_offset_q + 5'd1;
                        end
                    end
                    CONFIRM: begin
                        if (match) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_q + 4'd1 == LOCK_CNT) begin
                                state_d    = LOCKED;
                                miss_cnt_d = 4'd0;
                            end
                        end else begin
                            state_d      = HUNT;
                            bit_offset_d = bit_offset_q + 5'd1;
                            match_cnt_d  = 4'd0;
                        end
                    end
                    LOCKED: begin
                        data_out_d       = window;
                        data_out_valid_d = 1'b1;
                        if (synch_mode) begin
                            if (match) begin
                                miss_cnt_d = 4'd0;
                            end else if (miss_cnt_q + 4'd1 == UNLOCK_CNT) begin
                                // Lock lost: keep the offset so a re-hunt starts where it was.
                                state_d     = HUNT;
                                match_cnt_d = 4'd0;
                                miss_cnt_d  = 4'd0;
                                if (lock_loss_cnt_q != 8'hFF) begin
                                    lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                                end
                            end else begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state_q          <= HUNT;
            bit_offset_q     <= 5'd0;
            prev_word_q      <= '0;
            prev_valid_q     <= 1'b0;
            match_cnt_q      <= 4'd0;
            miss_cnt_q       <= 4'd0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            lock_loss_cnt_q  <= 8'd0;
        end else begin
            state_q          <= state_d;
            bit_offset_q     <= bit_offset_d;
            prev_word_q      <= prev_word_d;
            prev_valid_q     <= prev_valid_d;
            match_cnt_q      <= match_cnt_d;
            miss_cnt_q       <= miss_cnt_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            lock_loss_cnt_q  <= lock_loss_cnt_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign locked         = (state_q == LOCKED);
    assign align_state    = state_q;
    assign bit_offset     = bit_offset_q;
    assign lock_loss_cnt  = lock_loss_cnt_q;

endmodule

// File: doc/ldtu_rx_word_aligner.md
Name: ldtu_rx_word_aligner

Overview:
- Back-end receiver stage directly downstream of the LiTE-DTU output lanes. One instance per lane.
- Takes the 32-bit words recovered by the deserializer of one DTU lane; these words have an arbitrary, unknown bit rotation.
- Finds the bit offset by hunting for the DTU synch pattern while the DTU is in synch mode.
- Once locked, delivers correctly aligned 32-bit words downstream and monitors lock loss.

Parameters:
- Nbits_32, 32, word width; fixed at 32 (offset field is 5 bits).
- LockCount, 4, consecutive synch matches at one offset required to declare lock (1..15).
- UnlockCount, 3, consecutive synch mismatches in LOCKED with synch_mode=1 that drop lock (1..15).

Ports:
- CLK  in  1  lane word clock; all logic on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- data_in  in  32  deserialized word, unknown rotation.
- data_valid  in  1  data_in valid this cycle.
- synch_mode  in  1  DTU currently transmitting synch_pattern (mirror of DTU synch control).
- synch_pattern  in  32  expected synch word, same value as programmed into the DTU.
- realign  in  1  synchronous single-cycle request to restart the search.
- data_out  out  32  aligned word.
- data_out_valid  out  1  data_out valid.
- locked  out  1  state==LOCKED.
- align_state  out  2  00 HUNT, 01 CONFIRM, 10 LOCKED.
- bit_offset  out  5  current window offset.
- lock_loss_cnt  out  8  saturating count of LOCKED->HUNT transitions caused by mismatches.

Behaviour:
- Reset (async, rst_b=0): state HUNT; bit_offset=0; prev_word=0; prev_valid=0; match_cnt=0; miss_cnt=0; data_out=0; data_out_valid=0; locked=0; lock_loss_cnt=0.
- All state updates occur only on cycles with data_valid=1, except realign. With data_valid=0 everything holds and data_out_valid=0.
- Window: concat = {data_in, prev_word} (64 bits); window(k) = concat[k+31:k]. Offset 0 gives prev_word. prev_word <= data_in on every valid cycle; prev_valid <= 1.
- Comparison is made only when prev_valid=1. The first valid word after reset or realign is only captured.
- HUNT:
  - window(bit_offset)==synch_pattern: match_cnt=1, go to CONFIRM. If LockCount==1, go directly to LOCKED.
  - Otherwise bit_offset+1, wrapping 31->0.
- CONFIRM:
  - match: match_cnt+1. When it reaches LockCount, go to LOCKED and clear miss_cnt.
  - mismatch: go to HUNT, bit_offset+1 (wrapping), match_cnt=0.
- LOCKED:
  - Every valid cycle: data_out<=window(bit_offset), data_out_valid<=1. This covers both synch and payload words, with 1-cycle register latency from the data_in valid cycle.
  - The cycle that completes lock does not itself produce output; the first output follows the next valid word.
  - synch_mode=1 and mismatch: miss_cnt+1. On reaching UnlockCount: go to HUNT with bit_offset unchanged, lock_loss_cnt+1 (saturating at 255), match_cnt=0, miss_cnt=0.
  - synch_mode=1 and match: miss_cnt=0.
  - synch_mode=0: no checking; miss_cnt holds.
- realign=1 has highest priority, regardless of data_valid:
  - Next state HUNT; bit_offset=0; prev_valid=0; counters cleared except lock_loss_cnt; data_out_valid=0.
  - The concurrent data_in is discarded.
- data_out holds its last value when data_out_valid=0.
- Combinational outputs: locked and align_state decode the registered state.
- Reset mid-operation: immediate clear of all outputs; no output pulse on reset release.

Test Plan:
- Aligned lock: synch_pattern=0x5A3C_96E1, synch_mode=1, 6 valid words of pattern at rotation 0.
  - bit_offset=0, CONFIRM after word 2, LOCKED after word 5.
  - data_out=0x5A3C_96E1 with data_out_valid after word 6.
- Rotated lock: bitstream built so the true word = {cur[7:0], prev[31:8]}.
  - Offsets 0..7 fail on words 2..9.
  - Match at offset 8 on word 10; LOCKED after word 13; bit_offset=8.
- Unlock: LOCKED, synch_mode=1, 2 corrupted words then 1 good word -> stays LOCKED, miss_cnt cleared.
  - Then 3 corrupted words -> HUNT, lock_loss_cnt=1, bit_offset unchanged.
- Payload pass-through: LOCKED at offset 8, synch_mode=0, random payload words.
  - data_out equals the expected realigned words, 1 cycle later, with no unlock.
  - Inserting 2-cycle data_valid gaps gives no state change and data_out_valid=0 during the gaps.
- realign: pulse coincident with a valid matching word while LOCKED.
  - Next cycle HUNT, bit_offset=0, data_out_valid=0.
  - Lock recovers after 1+LockCount valid synch words.
- Async reset: assert rst_b=0 mid-CONFIRM (match_cnt=2).
  - All outputs are 0 within the same cycle.
  - After release, lock needs the full sequence again.
